// File: rtl/unified_mem_arbiter.sv
// Serialises fetch and data requests onto one memory bus, one transaction in flight.
// Optional UNIFIED_MEM_ARB_RR_EN selects round-robin; default is fixed dmem priority.
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    imem_req_i,
    input  logic [ADDR_WIDTH-1:0]   imem_addr_i,
    output logic [DATA_WIDTH-1:0]   imem_rdata_o,
    output logic                    imem_ready_o,
    input  logic                    dmem_read_i,
    input  logic                    dmem_write_i,
    input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] dmem_wstrb_i,
    output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
    output logic                    dmem_ready_o,
    output logic                    mem_read_o,
    output logic                    mem_write_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                    mem_ready_i,
    output logic                    protocol_err_o
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    state_t state_q, state_d;

    logic                  i_vld_q;
    logic [ADDR_WIDTH-1:0] i_addr_q;
    logic                  d_vld_q;
    logic                  d_wr_q;
    logic [ADDR_WIDTH-1:0] d_addr_q;
    logic [DATA_WIDTH-1:0] d_wdata_q;
    logic [STRB_WIDTH-1:0] d_wstrb_q;

    logic                  cur_wr_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [STRB_WIDTH-1:0] mem_wstrb_q;
    logic                  err_q;

    logic                  d_req, i_acc, d_acc, i_eff, d_eff, pick_d;
    logic                  grant_i, grant_d, err_set;
    logic [ADDR_WIDTH-1:0] d_addr_eff;
    logic [DATA_WIDTH-1:0] d_wdata_eff;
    logic [STRB_WIDTH-1:0] d_wstrb_eff;
    logic                  d_wr_eff;

    // A pulse is accepted only into a free slot; a port's own completion frees it.
    assign d_req = dmem_read_i | dmem_write_i;
    assign i_acc = imem_req_i && !i_vld_q && !(state_q == BUSY_I && !mem_ready_i);
    assign d_acc = d_req && !d_vld_q && !(state_q == BUSY_D && !mem_ready_i);
    assign i_eff = i_vld_q | i_acc;
    assign d_eff = d_vld_q | d_acc;

    assign d_addr_eff  = d_vld_q ? d_addr_q  : dmem_addr_i;
    assign d_wdata_eff = d_vld_q ? d_wdata_q : dmem_wdata_i;
    assign d_wstrb_eff = d_vld_q ? d_wstrb_q : dmem_wstrb_i;
    assign d_wr_eff    = d_vld_q ? d_wr_q    : (dmem_write_i & ~dmem_read_i);

    assign err_set = (imem_req_i && !i_acc) || (d_req && !d_acc) ||
                     (dmem_read_i && dmem_write_i);

`ifdef UNIFIED_MEM_ARB_RR_EN
    logic rr_d_q;
    assign pick_d = d_eff && (!i_eff || rr_d_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_d_q <= 1'b1;
        end else if (grant_i) begin
            rr_d_q <= 1'b1;
        end else if (grant_d) begin
            rr_d_q <= 1'b0;
        end
    end
`else
    assign pick_d = d_eff;
`endif

    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    grant_d = 1'b1;
                    state_d = BUSY_D;
                end else if (i_eff) begin
                    grant_i = 1'b1;
                    state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Slots: a grant in the capture cycle bypasses the slot entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_vld_q   <= 1'b0;
            i_addr_q  <= '0;
            d_vld_q   <= 1'b0;
            d_wr_q    <= 1'b0;
            d_addr_q  <= '0;
            d_wdata_q <= '0;
            d_wstrb_q <= '0;
        end else begin
            if (grant_i) begin
                i_vld_q <= 1'b0;
            end else if (i_acc) begin
                i_vld_q  <= 1'b1;
                i_addr_q <= imem_addr_i;
            end
            if (grant_d) begin
                d_vld_q <= 1'b0;
            end else if (d_acc) begin
                d_vld_q   <= 1'b1;
                d_wr_q    <= dmem_write_i & ~dmem_read_i;
                d_addr_q  <= dmem_addr_i;
                d_wdata_q <= dmem_wdata_i;
                d_wstrb_q <= dmem_wstrb_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_wr_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else if (grant_d) begin
            cur_wr_q    <= d_wr_eff;
            mem_read_q  <= ~d_wr_eff;
            mem_write_q <= d_wr_eff;
            mem_addr_q  <= d_addr_eff;
            mem_wdata_q <= d_wdata_eff;
            mem_wstrb_q <= d_wstrb_eff;
        end else if (grant_i) begin
            cur_wr_q    <= 1'b0;
            mem_read_q  <= 1'b1;
            mem_write_q <= 1'b0;
            mem_addr_q  <= i_eff && i_vld_q ? i_addr_q : imem_addr_i;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '1;
        end else begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (state_q != IDLE && mem_ready_i) begin
                cur_wr_q    <= 1'b0;
                mem_addr_q  <= '0;
                mem_wdata_q <= '0;
                mem_wstrb_q <= '0;
            end
        end
    end

    assign mem_read_o     = mem_read_q;
    assign mem_write_o    = mem_write_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign mem_wstrb_o    = mem_wstrb_q;
    assign protocol_err_o = err_q;

    assign imem_ready_o = (state_q == BUSY_I) && mem_ready_i;
    assign dmem_ready_o = (state_q == BUSY_D) && mem_ready_i;
    assign imem_rdata_o = imem_ready_o ? mem_rdata_i : '0;
    assign dmem_rdata_o = (dmem_ready_o && !cur_wr_q) ? mem_rdata_i : '0;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Cycle-stepped random and directed stimulus against a request-level reference model.
module tb_unified_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_i = 1'b0;
    logic [31:0] imem_addr_i = '0;
    logic [31:0] imem_rdata_o;
    logic        imem_ready_o;
    logic        dmem_read_i = 1'b0;
    logic        dmem_write_i = 1'b0;
    logic [31:0] dmem_addr_i = '0;
    logic [31:0] dmem_wdata_i = '0;
    logic [3:0]  dmem_wstrb_i = '0;
    logic [31:0] dmem_rdata_o;
    logic        dmem_ready_o;
    logic        mem_read_o, mem_write_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ready_i = 1'b0;
    logic        protocol_err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i),
        .imem_rdata_o(imem_rdata_o), .imem_ready_o(imem_ready_o),
        .dmem_read_i(dmem_read_i), .dmem_write_i(dmem_write_i),
        .dmem_addr_i(dmem_addr_i), .dmem_wdata_i(dmem_wdata_i),
        .dmem_wstrb_i(dmem_wstrb_i), .dmem_rdata_o(dmem_rdata_o),
        .dmem_ready_o(dmem_ready_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_rdata_i(mem_rdata_i),
        .mem_ready_i(mem_ready_i), .protocol_err_o(protocol_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference model: at most one waiting request per port, one transaction owner.
    int          owner;        // 0 none, 1 fetch, 2 data
    bit          first_cycle;
    bit          cur_wr;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_wstrb;
    bit          ip_v;
    logic [31:0] ip_addr;
    bit          dp_v, dp_wr;
    logic [31:0] dp_addr, dp_wdata;
    logic [3:0]  dp_wstrb;
    bit          err;
    bit          prefer_d;
    int          issues_d, issues_i;

    task automatic model_reset();
        owner = 0; first_cycle = 0; cur_wr = 0;
        cur_addr = '0; cur_wdata = '0; cur_wstrb = '0;
        ip_v = 0; dp_v = 0; err = 0; prefer_d = 1;
    endtask

    task automatic model_edge(input bit ireq, input logic [31:0] iaddr,
                              input bit drd, input bit dwr, input logic [31:0] daddr,
                              input logic [31:0] dwdata, input logic [3:0] dwstrb,
                              input bit mrdy);
        bit done;
        bit was_idle;
        bit take_d;
        done = (owner != 0) && mrdy;
        was_idle = (owner == 0);
        if (ireq) begin
            if (ip_v || (owner == 1 && !done)) err = 1;
            else begin ip_v = 1; ip_addr = iaddr; end
        end
        if (drd || dwr) begin
            if (drd && dwr) err = 1;
            if (dp_v || (owner == 2 && !done)) err = 1;
            else begin
                dp_v = 1; dp_wr = dwr && !drd;
                dp_addr = daddr; dp_wdata = dwdata; dp_wstrb = dwstrb;
            end
        end
        first_cycle = 0;
        if (was_idle && (ip_v || dp_v)) begin
`ifdef UNIFIED_MEM_ARB_RR_EN
            take_d = dp_v && (!ip_v || prefer_d);
`else
            take_d = dp_v;
`endif
            first_cycle = 1;
            if (take_d) begin
                owner = 2; cur_wr = dp_wr; cur_addr = dp_addr;
                cur_wdata = dp_wdata; cur_wstrb = dp_wstrb; dp_v = 0;
                prefer_d = 0; issues_d++;
            end else begin
                owner = 1; cur_wr = 0; cur_addr = ip_addr;
                cur_wdata = '0; cur_wstrb = 4'hF; ip_v = 0;
                prefer_d = 1; issues_i++;
            end
        end else if (done) begin
            owner = 0; cur_wr = 0; cur_addr = '0; cur_wdata = '0; cur_wstrb = '0;
        end
    endtask

    task automatic step(input bit ireq, input logic [31:0] iaddr,
                        input bit drd, input bit dwr, input logic [31:0] daddr,
                        input logic [31:0] dwdata, input logic [3:0] dwstrb,
                        input bit mrdy, input logic [31:0] mrdata, input bit rst);
        bit busy;
        imem_req_i = ireq; imem_addr_i = iaddr;
        dmem_read_i = drd; dmem_write_i = dwr; dmem_addr_i = daddr;
        dmem_wdata_i = dwdata; dmem_wstrb_i = dwstrb;
        mem_ready_i = mrdy; mem_rdata_i = mrdata;
        rst_n = !rst;
        if (rst) model_reset();
        @(negedge clk);
        busy = (owner != 0);
        chk("mem_read",  {31'b0, mem_read_o},  {31'b0, busy && first_cycle && !cur_wr});
        chk("mem_write", {31'b0, mem_write_o}, {31'b0, busy && first_cycle && cur_wr});
        chk("mem_addr",  mem_addr_o,  cur_addr);
        chk("mem_wdata", mem_wdata_o, cur_wdata);
        chk("mem_wstrb", {28'b0, mem_wstrb_o}, {28'b0, cur_wstrb});
        chk("imem_ready", {31'b0, imem_ready_o}, {31'b0, owner == 1 && mrdy});
        chk("imem_rdata", imem_rdata_o, (owner == 1 && mrdy) ? mrdata : 32'h0);
        chk("dmem_ready", {31'b0, dmem_ready_o}, {31'b0, owner == 2 && mrdy});
        chk("dmem_rdata", dmem_rdata_o, (owner == 2 && mrdy && !cur_wr) ? mrdata : 32'h0);
        chk("protocol_err", {31'b0, protocol_err_o}, {31'b0, err});
        @(posedge clk);
        if (!rst) model_edge(ireq, iaddr, drd, dwr, daddr, dwdata, dwstrb, mrdy);
        #1;
    endtask

    task automatic idle(input bit mrdy, input logic [31:0] mrdata);
        step(0, '0, 0, 0, '0, '0, '0, mrdy, mrdata, 0);
    endtask

    initial begin
        int i0, d0;
        model_reset();
        issues_d = 0; issues_i = 0;
        #1;
        step(0, '0, 0, 0, '0, '0, '0, 1, 32'h1234, 1);
        step(0, '0, 0, 0, '0, '0, '0, 0, '0, 1);
        idle(1, 32'h5555);                          // stray ready while idle

        // Single fetch with two wait cycles.
        step(1, 32'h100, 0, 0, '0, '0, '0, 0, '0, 0);
        idle(0, '0);
        idle(0, '0);
        idle(1, 32'h00500093);
        idle(0, '0);

        // Data write.
        step(0, '0, 0, 1, 32'h2000, 32'hDEADBEEF, 4'h3, 0, '0, 0);
        idle(1, 32'hFFFF0000);
        idle(0, '0);

        // Simultaneous requests, twice.
        repeat (2) begin
            d0 = issues_d; i0 = issues_i;
            step(1, 32'h40, 1, 0, 32'h80, '0, 4'hF, 0, '0, 0);
            chk("sim_first_d", issues_d - d0,
`ifdef UNIFIED_MEM_ARB_RR_EN
                (d0 + i0 == 2 * d0 && issues_d == d0) ? 0 : issues_d - d0);
`else
                1);
`endif
            idle(1, 32'hA5A5A5A5);
            idle(0, '0);
            idle(1, 32'h5A5A5A5A);
            idle(0, '0);
            chk("sim_both_issued", (issues_d - d0) + (issues_i - i0), 2);
        end

        // Repeat request on the port whose completion fires the same cycle.
        step(1, 32'h200, 0, 0, '0, '0, '0, 0, '0, 0);
        step(1, 32'h204, 0, 0, '0, '0, '0, 1, 32'h11, 0);
        idle(0, '0);
        idle(1, 32'h22);
        idle(0, '0);
        chk("err_clean", {31'b0, protocol_err_o}, 32'h0);

        // Second read in flight is dropped, then read+write together.
        d0 = issues_d;
        step(0, '0, 1, 0, 32'h300, '0, 4'hF, 0, '0, 0);
        step(0, '0, 1, 0, 32'h304, '0, 4'hF, 0, '0, 0);
        idle(1, 32'h77);
        idle(0, '0);
        idle(0, '0);
        chk("drop_second", issues_d - d0, 1);
        step(0, '0, 1, 1, 32'h400, 32'h99, 4'hF, 1, '0, 0);
        idle(1, 32'h88);
        idle(0, '0);

        // Reset while BUSY_D, then stray ready after release.
        step(0, '0, 1, 0, 32'h500, '0, 4'hF, 0, '0, 0);
        idle(0, '0);
        step(0, '0, 0, 0, '0, '0, '0, 0, '0, 1);
        idle(1, 32'hBAD);
        idle(0, '0);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            bit ir, dr, dw, mr, rs;
            ir = ($urandom_range(0, 3) == 0);
            dr = ($urandom_range(0, 4) == 0);
            dw = ($urandom_range(0, 5) == 0);
            mr = ($urandom_range(0, 2) != 0);
            rs = ($urandom_range(0, 499) == 0);
            step(ir, $urandom, dr, dw, $urandom, $urandom, 4'($urandom), mr, $urandom, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
